display_list_builder: RTL and testbench
=======================================

# display_list_builder

Builds the per-frame vector display list in RAM from up to NUM_SEG independent ROM segments (frame, map, cursor, targets, …), each individually enabled and translated by a per-segment (dx, dy) offset. It sits between the vector ROM/control units and the display-list RAM read by the bresenham line drawer. It pipelines ROM reads at a parametrised read latency. It guards against RAM overflow and unterminated segments, and latches frame_done requests that arrive early.

## Interface
- OUT_WIDTH, 8, coordinate width
- ADR_WIDTH, 16, ROM/RAM address width
- DATAWIDTH, 2*OUT_WIDTH+2, word {x, y, line, pos}
- NUM_SEG, 4, number of segments (1..16)
- ROM_LATENCY, 1, ROM read latency in cycles (1..3)
- RAM_DEPTH, 4096, display-list RAM words
- MAX_SEG_LEN, 1024, max words copied per segment

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- frame_done  in  1  drawer finished the current list
- seg_en  in  NUM_SEG  segment enable mask
- seg_base  in  NUM_SEG*ADR_WIDTH  ROM start address per segment (segment i at bits [i*ADR_WIDTH +: ADR_WIDTH])
- seg_dx, seg_dy  in  NUM_SEG*OUT_WIDTH  unsigned offsets per segment
- dataROM  in  DATAWIDTH  ROM read data
- adrROM  out  ADR_WIDTH  ROM read address
- dataWRITE  out  DATAWIDTH  RAM write data
- adrWRITE  out  ADR_WIDTH  RAM write address
- we  out  1  RAM write strobe
- draw_frame  out  1  list complete, drawer may run
- busy  out  1  build in progress
- overflow  out  1  words dropped this frame (sticky until next build)
- seg_err  out  NUM_SEG  segment hit MAX_SEG_LEN without a terminator (sticky until next build)
- state_debug  out  4  current state encoding

## Operation
- Terminator word: line=1 and pos=1. It is never copied from ROM.
- States: RESET → START → SEG_SEL → FETCH → FLUSH → (SEG_SEL | TERM) → DONE → WAIT_FRAME.
- RESET: all outputs 0, pending flag 0, seg index 0.
- START:
  - Sample seg_en, seg_base, seg_dx, seg_dy into registers (stable for the whole build).
  - Clear overflow and seg_err.
  - Write {0,0,0,1} (move to origin) at adrWRITE=0.
- SEG_SEL:
  - Advance to the lowest enabled index ≥ current index; skip disabled segments at 1 cycle each.
  - Load adrROM = base and reset the segment word counter.
  - If no enabled segment remains → TERM.
- FETCH:
  - adrROM increments every cycle; a ROM_LATENCY-deep valid shift register tags the returning words.
  - Each valid non-terminator word is written at adrWRITE+1 as {sat(x+dx), sat(y+dy), line, pos}.
  - sat clamps the OUT_WIDTH+1-bit sum to 2^OUT_WIDTH−1.
  - A valid terminator, or the counter reaching MAX_SEG_LEN (also sets seg_err[i]), ends the segment → FLUSH.
- FLUSH: stop issuing addresses, discard the ROM_LATENCY−1 in-flight words, index+1 → SEG_SEL.
- Overflow: the last RAM slot (RAM_DEPTH−1) is reserved for the terminator. Once adrWRITE = RAM_DEPTH−2 has been written, further vertex writes are suppressed, overflow=1, and copying continues (discarding words) to the terminator.
- TERM: write {0,0,1,1} at adrWRITE+1 (≤ RAM_DEPTH−1).
- DONE: draw_frame=1, busy=0.
- WAIT_FRAME:
  - draw_frame=1.
  - On frame_done, or if the pending flag is set → START; clear pending.
- frame_done asserted in any state other than WAIT_FRAME sets pending.
- rst mid-build: abort immediately to RESET. RAM contents are don't-care; a new build starts after reset.

## Timing
- All outputs are registered. Reset values are 0 for every output.
- RESET → START on the cycle after rst deasserts. The first build needs no frame_done.
- we is high exactly in the cycles where dataWRITE/adrWRITE are valid. adrWRITE is strictly +1 per write.
- Steady-state throughput: 1 RAM word per cycle within a segment.
- Per-segment overhead: 1 (SEG_SEL) + ROM_LATENCY (pipeline fill) + 1 (FLUSH) cycles.
- WAIT_FRAME → START takes 1 cycle after frame_done is sampled.
- draw_frame falls in the same cycle busy rises.

## Structure
- Package display_pkg:
  - state_t enum
  - TERM_WORD and ORIGIN_WORD constants
  - pack_word/unpack_word functions
  - is_term function
- Sub-module vertex_xform: combinational offset add + saturate on one word; registered in the parent's write stage.

## Test plan
- NUM_SEG=2, ROM_LATENCY=1, both enabled, seg0 = 3 vertices + term, seg1 = 2 vertices + term, zero offsets → RAM[0]={0,0,0,1}, RAM[1..5] = the vertices in order, RAM[6]={0,0,1,1}, draw_frame=1.
- seg_dx=250, seg_dy=3, vertex (10,20) → written (255,23); vertex (4,4) → (254,7).
- seg_en=4'b1010, ROM_LATENCY=3 → only segs 1 and 3 are copied; no post-terminator word is ever written; same RAM image as with ROM_LATENCY=1.
- RAM_DEPTH=8, one segment of 12 vertices → RAM[1..6] written, RAM[7]=terminator, overflow=1.
- Segment without terminator, MAX_SEG_LEN=16 → exactly 16 words copied, seg_err[i]=1, next segment still built.
- frame_done pulsed mid-build → START follows DONE+WAIT_FRAME directly. rst asserted during FETCH → all outputs 0 next cycle, fresh build from START.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared state encoding, word constants and
// helpers for the display-list builder.
package display_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_START,
      S_SEG_SEL,
      S_FETCH,
      S_FLUSH,
      S_TERM,
      S_DONE,
      S_WAIT_FRAME
   } state_t;

   // widest coordinate the helpers handle
   localparam int CW = 16;
   localparam int WW = 2*CW+2;

   // both have zero coordinates, so the value is width independent
   localparam int unsigned TERM_WORD   = 3;
   localparam int unsigned ORIGIN_WORD = 1;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          line;
      logic          pos;
   } vertex_t;

   function automatic vertex_t unpack_word(
      input logic [WW-1:0] w,
      input int unsigned   ow
   );
      vertex_t       v;
      logic [CW-1:0] m;
      m      = CW'((33'd1 << ow) - 33'd1);
      v.x    = CW'(w >> (ow + 2)) & m;
      v.y    = CW'(w >> 2) & m;
      v.line = w[1];
      v.pos  = w[0];
      return v;
   endfunction

   function automatic logic [WW-1:0] pack_word(
      input vertex_t     v,
      input int unsigned ow
   );
      return (WW'(v.x) << (ow + 2))
           | (WW'(v.y) << 2)
           | WW'({v.line, v.pos});
   endfunction

   function automatic logic is_term(input logic [1:0] lp);
      return lp == 2'b11;
   endfunction

endpackage

// File: rtl/vertex_xform.sv
// vertex_xform: translates one display word by (dx, dy),
// clamping each coordinate at its top value.
module vertex_xform
   import display_pkg::*;
#(
   parameter int OUT_WIDTH = 8,
   parameter int DATAWIDTH = 2*OUT_WIDTH+2
) (
   input  logic [DATAWIDTH-1:0] din,
   input  logic [OUT_WIDTH-1:0] dx,
   input  logic [OUT_WIDTH-1:0] dy,
   output logic [DATAWIDTH-1:0] dout
);

   vertex_t            v_in;
   vertex_t            v_out;
   logic [OUT_WIDTH:0] sx;
   logic [OUT_WIDTH:0] sy;

   // widen by one bit, add, saturate on carry out
   always_comb begin
      v_in  = unpack_word(WW'(din), OUT_WIDTH);
      sx    = {1'b0, v_in.x[OUT_WIDTH-1:0]} + {1'b0, dx};
      sy    = {1'b0, v_in.y[OUT_WIDTH-1:0]} + {1'b0, dy};
      v_out = v_in;
      v_out.x = sx[OUT_WIDTH] ? CW'({OUT_WIDTH{1'b1}})
                              : CW'(sx[OUT_WIDTH-1:0]);
      v_out.y = sy[OUT_WIDTH] ? CW'({OUT_WIDTH{1'b1}})
                              : CW'(sy[OUT_WIDTH-1:0]);
      dout  = DATAWIDTH'(pack_word(v_out, OUT_WIDTH));
   end

endmodule

// File: rtl/display_list_builder.sv
// display_list_builder: copies enabled ROM segments, offset
// and clamped, into the display-list RAM, then terminates it.
module display_list_builder
   import display_pkg::*;
#(
   parameter int OUT_WIDTH   = 8,
   parameter int ADR_WIDTH   = 16,
   parameter int DATAWIDTH   = 2*OUT_WIDTH+2,
   parameter int NUM_SEG     = 4,
   parameter int ROM_LATENCY = 1,
   parameter int RAM_DEPTH   = 4096,
   parameter int MAX_SEG_LEN = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_done,
   input  logic [NUM_SEG-1:0]           seg_en,
   input  logic [NUM_SEG*ADR_WIDTH-1:0] seg_base,
   input  logic [NUM_SEG*OUT_WIDTH-1:0] seg_dx,
   input  logic [NUM_SEG*OUT_WIDTH-1:0] seg_dy,
   input  logic [DATAWIDTH-1:0]         dataROM,
   output logic [ADR_WIDTH-1:0]         adrROM,
   output logic [DATAWIDTH-1:0]         dataWRITE,
   output logic [ADR_WIDTH-1:0]         adrWRITE,
   output logic                         we,
   output logic                         draw_frame,
   output logic                         busy,
   output logic                         overflow,
   output logic [NUM_SEG-1:0]           seg_err,
   output logic [3:0]                   state_debug
);

   localparam int IW  = $clog2(NUM_SEG + 1);
   localparam int CNW = $clog2(MAX_SEG_LEN + 1);
   localparam int L   = ROM_LATENCY;
   localparam logic [ADR_WIDTH-1:0] LAST_VTX =
      ADR_WIDTH'(RAM_DEPTH - 2);

   state_t                       state, state_n;
   logic [IW-1:0]                seg_idx, seg_idx_n;
   logic                         pending, pending_n;
   logic [NUM_SEG-1:0]           en_r, en_n;
   logic [NUM_SEG*ADR_WIDTH-1:0] base_r, base_n;
   logic [NUM_SEG*OUT_WIDTH-1:0] dx_r, dx_n;
   logic [NUM_SEG*OUT_WIDTH-1:0] dy_r, dy_n;
   logic [CNW-1:0]               cnt, cnt_n;
   logic [L-1:0]                 pipe, pipe_n;

   logic [ADR_WIDTH-1:0]         adr_rom_n;
   logic [ADR_WIDTH-1:0]         adr_wr_n;
   logic [DATAWIDTH-1:0]         data_wr_n;
   logic                         we_n;
   logic                         draw_n;
   logic                         busy_n;
   logic                         ovf_n;
   logic [NUM_SEG-1:0]           err_n;
   logic                         start_build;

   logic                         cur_en;
   logic [NUM_SEG-1:0]           cur_bit;
   logic [ADR_WIDTH-1:0]         cur_base;
   logic [OUT_WIDTH-1:0]         cur_dx;
   logic [OUT_WIDTH-1:0]         cur_dy;
   logic [DATAWIDTH-1:0]         xf_word;

   assign state_debug = state;

   // pick the sampled parameters of the current segment
   always_comb begin
      cur_en   = 1'b0;
      cur_bit  = '0;
      cur_base = '0;
      cur_dx   = '0;
      cur_dy   = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         if (seg_idx == IW'(i)) begin
            cur_en     = en_r[i];
            cur_bit[i] = 1'b1;
            cur_base   = base_r[i*ADR_WIDTH +: ADR_WIDTH];
            cur_dx     = dx_r[i*OUT_WIDTH +: OUT_WIDTH];
            cur_dy     = dy_r[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   vertex_xform #(
      .OUT_WIDTH (OUT_WIDTH),
      .DATAWIDTH (DATAWIDTH)
   ) u_xform (
      .din  (dataROM),
      .dx   (cur_dx),
      .dy   (cur_dy),
      .dout (xf_word)
   );

   // next state plus the registered outputs of that state
   always_comb begin
      state_n     = state;
      seg_idx_n   = seg_idx;
      pending_n   = pending
                  | (frame_done && (state != S_WAIT_FRAME));
      en_n        = en_r;
      base_n      = base_r;
      dx_n        = dx_r;
      dy_n        = dy_r;
      cnt_n       = cnt;
      pipe_n      = pipe;
      adr_rom_n   = adrROM;
      adr_wr_n    = adrWRITE;
      data_wr_n   = dataWRITE;
      we_n        = 1'b0;
      draw_n      = draw_frame;
      busy_n      = busy;
      ovf_n       = overflow;
      err_n       = seg_err;
      start_build = 1'b0;

      unique case (state)
         S_RESET: start_build = 1'b1;
         S_START: state_n = S_SEG_SEL;
         S_SEG_SEL: begin
            pipe_n = '0;
            cnt_n  = '0;
            if (seg_idx >= IW'(NUM_SEG)) begin
               state_n   = S_TERM;
               we_n      = 1'b1;
               adr_wr_n  = adrWRITE + ADR_WIDTH'(1);
               data_wr_n = DATAWIDTH'(TERM_WORD);
            end else if (cur_en) begin
               state_n   = S_FETCH;
               adr_rom_n = cur_base;
            end else begin
               seg_idx_n = seg_idx + IW'(1);
            end
         end
         S_FETCH: begin
            adr_rom_n = adrROM + ADR_WIDTH'(1);
            pipe_n    = L'({pipe, 1'b1});
            if (pipe[L-1]) begin
               if (is_term(dataROM[1:0])) begin
                  state_n = S_FLUSH;
               end else begin
                  cnt_n = cnt + CNW'(1);
                  if (adrWRITE == LAST_VTX) begin
                     ovf_n = 1'b1;
                  end else begin
                     we_n      = 1'b1;
                     adr_wr_n  = adrWRITE + ADR_WIDTH'(1);
                     data_wr_n = xf_word;
                  end
                  if (cnt_n == CNW'(MAX_SEG_LEN)) begin
                     state_n = S_FLUSH;
                     err_n   = seg_err | cur_bit;
                  end
               end
            end
            if (state_n == S_FLUSH) pipe_n = '0;
         end
         S_FLUSH: begin
            pipe_n    = '0;
            seg_idx_n = seg_idx + IW'(1);
            state_n   = S_SEG_SEL;
         end
         S_TERM: begin
            state_n = S_DONE;
            draw_n  = 1'b1;
            busy_n  = 1'b0;
         end
         S_DONE: state_n = S_WAIT_FRAME;
         S_WAIT_FRAME: begin
            if (frame_done || pending) begin
               start_build = 1'b1;
               pending_n   = 1'b0;
            end
         end
         default: state_n = S_RESET;
      endcase

      if (start_build) begin
         state_n   = S_START;
         en_n      = seg_en;
         base_n    = seg_base;
         dx_n      = seg_dx;
         dy_n      = seg_dy;
         seg_idx_n = '0;
         ovf_n     = 1'b0;
         err_n     = '0;
         we_n      = 1'b1;
         adr_wr_n  = '0;
         data_wr_n = DATAWIDTH'(ORIGIN_WORD);
         draw_n    = 1'b0;
         busy_n    = 1'b1;
      end
   end

   // state and output registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RESET;
         seg_idx    <= '0;
         pending    <= 1'b0;
         en_r       <= '0;
         base_r     <= '0;
         dx_r       <= '0;
         dy_r       <= '0;
         cnt        <= '0;
         pipe       <= '0;
         adrROM     <= '0;
         adrWRITE   <= '0;
         dataWRITE  <= '0;
         we         <= 1'b0;
         draw_frame <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         seg_err    <= '0;
      end else begin
         state      <= state_n;
         seg_idx    <= seg_idx_n;
         pending    <= pending_n;
         en_r       <= en_n;
         base_r     <= base_n;
         dx_r       <= dx_n;
         dy_r       <= dy_n;
         cnt        <= cnt_n;
         pipe       <= pipe_n;
         adrROM     <= adr_rom_n;
         adrWRITE   <= adr_wr_n;
         dataWRITE  <= data_wr_n;
         we         <= we_n;
         draw_frame <= draw_n;
         busy       <= busy_n;
         overflow   <= ovf_n;
         seg_err    <= err_n;
      end
   end

endmodule

// File: tb/tb_display_list_builder.sv
// tb_display_list_builder: directed checks of two builder
// instances (ROM latency 1 / large RAM, latency 3 / 8-word RAM).
module tb_display_list_builder;

   localparam int OW = 8;
   localparam int AW = 16;
   localparam int DW = 18;
   localparam int NS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_a, rst_b, frame_done;
   logic [NS-1:0]    seg_en;
   logic [NS*AW-1:0] seg_base;
   logic [NS*OW-1:0] seg_dx, seg_dy;

   logic [DW-1:0] drom_a, d1_b, d2_b, d3_b;
   logic [AW-1:0] arom_a, adrw_a, arom_b, adrw_b;
   logic [DW-1:0] dw_a, dw_b;
   logic          we_a, draw_a, busy_a, ovf_a;
   logic          we_b, draw_b, busy_b, ovf_b;
   logic [NS-1:0] err_a, err_b;
   logic [3:0]    sd_a, sd_b;

   logic [DW-1:0] rom [0:255];
   logic [DW-1:0] ram_a [0:63];
   logic [DW-1:0] ram_b [0:7];
   int            wcnt_a, wcnt_b;
   logic          ord_a, ord_b;
   logic          clr_a, clr_b;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q [$];

   display_list_builder #(
      .NUM_SEG(NS), .ROM_LATENCY(1),
      .RAM_DEPTH(4096), .MAX_SEG_LEN(16)
   ) dut_a (
      .clk(clk), .rst(rst_a), .frame_done(frame_done),
      .seg_en(seg_en), .seg_base(seg_base),
      .seg_dx(seg_dx), .seg_dy(seg_dy),
      .dataROM(drom_a), .adrROM(arom_a),
      .dataWRITE(dw_a), .adrWRITE(adrw_a), .we(we_a),
      .draw_frame(draw_a), .busy(busy_a),
      .overflow(ovf_a), .seg_err(err_a),
      .state_debug(sd_a)
   );

   display_list_builder #(
      .NUM_SEG(NS), .ROM_LATENCY(3),
      .RAM_DEPTH(8), .MAX_SEG_LEN(16)
   ) dut_b (
      .clk(clk), .rst(rst_b), .frame_done(frame_done),
      .seg_en(seg_en), .seg_base(seg_base),
      .seg_dx(seg_dx), .seg_dy(seg_dy),
      .dataROM(d3_b), .adrROM(arom_b),
      .dataWRITE(dw_b), .adrWRITE(adrw_b), .we(we_b),
      .draw_frame(draw_b), .busy(busy_b),
      .overflow(ovf_b), .seg_err(err_b),
      .state_debug(sd_b)
   );

   // ROMs with one and three cycles of read latency
   always @(posedge clk) drom_a <= rom[arom_a[7:0]];

   always @(posedge clk) begin
      d1_b <= rom[arom_b[7:0]];
      d2_b <= d1_b;
      d3_b <= d2_b;
   end

   // RAM A capture; address must equal the running write count
   always @(posedge clk) begin
      if (clr_a) begin
         for (int i = 0; i < 64; i++) ram_a[i] <= '0;
         wcnt_a <= 0;
         ord_a  <= 1'b0;
      end else if (we_a) begin
         ram_a[adrw_a[5:0]] <= dw_a;
         wcnt_a <= wcnt_a + 1;
         if (adrw_a != AW'(wcnt_a)) ord_a <= 1'b1;
      end
   end

   // RAM B capture
   always @(posedge clk) begin
      if (clr_b) begin
         for (int i = 0; i < 8; i++) ram_b[i] <= '0;
         wcnt_b <= 0;
         ord_b  <= 1'b0;
      end else if (we_b) begin
         ram_b[adrw_b[2:0]] <= dw_b;
         wcnt_b <= wcnt_b + 1;
         if (adrw_b != AW'(wcnt_b)) ord_b <= 1'b1;
      end
   end

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] wd(
      input int x, input int y, input logic ln, input logic ps
   );
      return {8'(x), 8'(y), ln, ps};
   endfunction

   task automatic cfg(
      input logic [3:0] en,
      input int b0, input int b1, input int b2, input int b3,
      input int dx0, input int dy0
   );
      seg_en   = en;
      seg_base = {AW'(b3), AW'(b2), AW'(b1), AW'(b0)};
      seg_dx   = {24'd0, 8'(dx0)};
      seg_dy   = {24'd0, 8'(dy0)};
   endtask

   // from WAIT_FRAME: clear the RAM model, then request a frame
   task automatic start(input bit b);
      @(negedge clk);
      if (b) clr_b = 1'b1; else clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      clr_b = 1'b0;
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   task automatic wait_draw(input bit b, input string tag);
      int n;
      n = 0;
      while (!(b ? draw_b : draw_a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " draw_frame in time"}, 64'(n < 300), 64'd1);
   endtask

   task automatic cmp_ram(input bit b, input string tag);
      logic [DW-1:0] got;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = b ? ram_b[i] : ram_a[i];
         chk($sformatf("%s ram[%0d]", tag, i), 64'(got),
             64'(exp_q[i]));
      end
      chk({tag, " words"}, 64'(b ? wcnt_b : wcnt_a),
          64'(exp_q.size()));
      chk({tag, " addr order"}, 64'(b ? ord_b : ord_a), 64'd0);
   endtask

   localparam logic [DW-1:0] ORG = 18'd1;
   localparam logic [DW-1:0] TRM = 18'd3;

   initial begin
      int n;
      rst_a = 1'b1;
      rst_b = 1'b1;
      clr_a = 1'b1;
      clr_b = 1'b1;
      frame_done = 1'b0;

      for (int i = 0; i < 256; i++) rom[i] = wd(8'h55, 8'h66, 1, 0);
      rom[16] = wd(1, 2, 0, 1);
      rom[17] = wd(3, 4, 1, 0);
      rom[18] = wd(5, 6, 1, 0);
      rom[19] = TRM;
      rom[32] = wd(7, 8, 0, 1);
      rom[33] = wd(9, 10, 1, 0);
      rom[34] = TRM;
      rom[48] = wd(10, 20, 1, 0);
      rom[49] = wd(4, 4, 0, 1);
      rom[50] = wd(0, 0, 1, 0);
      rom[51] = TRM;
      rom[64] = wd(11, 12, 1, 0);
      rom[65] = wd(13, 14, 1, 0);
      rom[66] = TRM;
      rom[72] = wd(15, 16, 0, 1);
      rom[73] = TRM;
      for (int i = 0; i < 12; i++) rom[96+i] = wd(i+1, 2*i, 1, 0);
      rom[108] = TRM;
      for (int i = 0; i < 20; i++) rom[128+i] = wd(i, i+100, 1, 0);
      rom[148] = TRM;

      cfg(4'b0011, 16, 32, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset outputs A",
          64'({arom_a, dw_a, adrw_a, we_a, draw_a, busy_a,
               ovf_a, err_a, sd_a}), 64'd0);
      chk("reset outputs B",
          64'({arom_b, dw_b, adrw_b, we_b, draw_b, busy_b,
               ovf_b, err_b, sd_b}), 64'd0);

      // first build starts without frame_done
      clr_a = 1'b0;
      clr_b = 1'b0;
      rst_a = 1'b0;
      @(negedge clk);
      chk("start busy", 64'(busy_a), 64'd1);
      chk("origin write",
          64'({we_a, adrw_a, dw_a}), 64'({1'b1, 16'd0, ORG}));

      wait_draw(0, "two seg");
      exp_q = {ORG, wd(1,2,0,1), wd(3,4,1,0), wd(5,6,1,0),
               wd(7,8,0,1), wd(9,10,1,0), TRM};
      cmp_ram(0, "two seg");
      chk("two seg busy", 64'(busy_a), 64'd0);
      chk("two seg flags", 64'({ovf_a, err_a}), 64'd0);

      // offsets with saturation
      cfg(4'b0001, 48, 0, 0, 0, 250, 3);
      start(0);
      wait_draw(0, "sat");
      exp_q = {ORG, wd(255,23,1,0), wd(254,7,0,1),
               wd(250,3,1,0), TRM};
      cmp_ram(0, "sat");

      // disabled segments are skipped
      cfg(4'b1010, 16, 64, 32, 72, 0, 0);
      start(0);
      wait_draw(0, "skip L1");
      exp_q = {ORG, wd(11,12,1,0), wd(13,14,1,0),
               wd(15,16,0,1), TRM};
      cmp_ram(0, "skip L1");

      // unterminated segment stops at 16 words
      cfg(4'b0011, 128, 32, 0, 0, 0, 0);
      start(0);
      wait_draw(0, "seg err");
      exp_q = {ORG};
      for (int i = 0; i < 16; i++) exp_q.push_back(wd(i, i+100, 1, 0));
      exp_q.push_back(wd(7, 8, 0, 1));
      exp_q.push_back(wd(9, 10, 1, 0));
      exp_q.push_back(TRM);
      cmp_ram(0, "seg err");
      chk("seg err flags", 64'({ovf_a, err_a}), 64'h1);
      repeat (3) @(negedge clk);
      chk("idle in wait", 64'({draw_a, busy_a}), 64'b10);

      // early frame_done is remembered
      cfg(4'b0011, 16, 32, 0, 0, 0, 0);
      start(0);
      repeat (3) @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      wait_draw(0, "pending");
      n = 0;
      while (draw_a && !busy_a && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("pending restart cycles", 64'(n), 64'd2);
      chk("pending restart outs", 64'({draw_a, busy_a}), 64'b01);
      wait_draw(0, "pending rebuild");

      // reset during FETCH
      start(0);
      n = 0;
      while (!(we_a && adrw_a == 16'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach fetch", 64'(n < 100), 64'd1);
      rst_a = 1'b1;
      @(negedge clk);
      chk("mid reset outputs",
          64'({arom_a, dw_a, adrw_a, we_a, draw_a, busy_a,
               ovf_a, err_a, sd_a}), 64'd0);
      rst_a = 1'b0;
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      chk("restart busy", 64'(busy_a), 64'd1);
      wait_draw(0, "after reset");
      exp_q = {ORG, wd(1,2,0,1), wd(3,4,1,0), wd(5,6,1,0),
               wd(7,8,0,1), wd(9,10,1,0), TRM};
      cmp_ram(0, "after reset");

      // instance B: latency 3 gives the same image
      rst_a = 1'b1;
      cfg(4'b1010, 16, 64, 32, 72, 0, 0);
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      rst_b = 1'b0;
      wait_draw(1, "skip L3");
      exp_q = {ORG, wd(11,12,1,0), wd(13,14,1,0),
               wd(15,16,0,1), TRM};
      cmp_ram(1, "skip L3");

      // 12 vertices into an 8-word RAM
      cfg(4'b0001, 96, 0, 0, 0, 0, 0);
      start(1);
      wait_draw(1, "overflow");
      exp_q = {ORG};
      for (int i = 0; i < 6; i++) exp_q.push_back(wd(i+1, 2*i, 1, 0));
      exp_q.push_back(TRM);
      cmp_ram(1, "overflow");
      chk("overflow flags", 64'({ovf_b, err_b}), 64'h10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
